// File: rtl/mux_tree_pipe_if.sv
// Bus bundle for mux_tree_pipe: packed channels, select, valid and clock
// enable in; selected channel, valid and range error out.
interface mux_tree_pipe_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_IN   = 8
);
  localparam int unsigned LEVELS = $clog2(N_IN);
  localparam int unsigned SEL_W  = (LEVELS > 1) ? LEVELS : 1;

  logic                     CE;
  logic [N_IN*DATA_W-1:0]   I;
  logic [SEL_W-1:0]         S;
  logic                     VI;
  logic [DATA_W-1:0]        O;
  logic                     VO;
  logic                     ERR;

  modport master (output CE, I, S, VI, input  O, VO, ERR);
  modport slave  (input  CE, I, S, VI, output O, VO, ERR);
endinterface

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 wide mux: binary tree of 2:1 levels with a register bank
// every REG_EVERY levels and always after the last level.
module mux_tree_pipe #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned N_IN      = 8,
  parameter int unsigned REG_EVERY = 1
) (
  input logic           CLK,
  input logic           RST,
  mux_tree_pipe_if.slave bus
);
  localparam int unsigned LEVELS = $clog2(N_IN);
  localparam int unsigned SEL_W  = (LEVELS > 1) ? LEVELS : 1;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned NI     = (N_IN + (1 << l) - 1) >> l;
    localparam int unsigned NO     = (NI + 1) / 2;
    localparam int unsigned SW     = SEL_W - l;
    localparam bit          LAST   = (l == LEVELS - 1);
    localparam bit          DO_REG = LAST || (((l + 1) % REG_EVERY) == 0);

    logic [DATA_W-1:0] w_a [NI];
    logic [SW-1:0]     w_sa;
    logic              w_va;
    logic              w_ea;
    logic [DATA_W-1:0] w_d [NO];
    logic [DATA_W-1:0] w_q [NO];
    logic              w_vq;
    logic              w_eq;

    // Level inputs: raw channels at the leaves, previous level otherwise.
    if (l == 0) begin : g_src
      for (genvar k = 0; k < N_IN; k++) begin : g_ch
        assign w_a[k] = bus.I[k*DATA_W +: DATA_W];
      end
      assign w_sa = bus.S;
      assign w_va = bus.VI;
      assign w_ea = (32'(bus.S) >= 32'(N_IN));
    end else begin : g_src
      assign w_a  = g_lvl[l-1].w_q;
      assign w_sa = g_lvl[l-1].g_sp.w_sq;
      assign w_va = g_lvl[l-1].w_vq;
      assign w_ea = g_lvl[l-1].w_eq;
    end

    // An unpaired last node yields zero when asked for its missing sibling.
    for (genvar j = 0; j < NO; j++) begin : g_node
      logic [DATA_W-1:0] w_mux;
      if (2*j + 1 < NI) begin : g_pair
        assign w_mux = w_sa[0] ? w_a[2*j+1] : w_a[2*j];
      end else begin : g_odd
        assign w_mux = w_sa[0] ? '0 : w_a[2*j];
      end
      assign w_d[j] = (LAST && w_ea) ? '0 : w_mux;
    end

    if (DO_REG) begin : g_reg
      logic [DATA_W-1:0] r_q [NO];
      logic              r_v;
      logic              r_e;
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_q <= '{default: '0};
          r_v <= 1'b0;
          r_e <= 1'b0;
        end else if (bus.CE) begin
          r_q <= w_d;
          r_v <= w_va;
          r_e <= w_ea;
        end
      end
      assign w_q  = r_q;
      assign w_vq = r_v;
      assign w_eq = r_e;
    end else begin : g_wire
      assign w_q  = w_d;
      assign w_vq = w_va;
      assign w_eq = w_ea;
    end

    // Select bits still needed by later levels ride along with the data.
    if (!LAST) begin : g_sp
      logic [SW-2:0] w_sq;
      if (DO_REG) begin : g_r
        logic [SW-2:0] r_sq;
        always_ff @(posedge CLK) begin
          if (RST)         r_sq <= '0;
          else if (bus.CE) r_sq <= w_sa[SW-1:1];
        end
        assign w_sq = r_sq;
      end else begin : g_w
        assign w_sq = w_sa[SW-1:1];
      end
    end
  end

  assign bus.O   = g_lvl[LEVELS-1].w_q[0];
  assign bus.VO  = g_lvl[LEVELS-1].w_vq;
  assign bus.ERR = g_lvl[LEVELS-1].w_eq;
endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: three N_IN=8 instances with REG_EVERY 1/2/3
// and one N_IN=5 instance, all checked every cycle against a delay-line model.
module tb_mux_tree_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ce;
  logic        vi;
  logic [2:0]  s8;
  logic [2:0]  s5;
  logic [63:0] i8;
  logic [39:0] i5;
  logic [2:0]  tab5 [8];
  int          checks = 0;
  int          errors = 0;

  // expected pipeline contents per instance; stage index st-1 is the output
  logic [7:0]  m_o [4][3];
  logic        m_v [4][3];
  logic        m_e [4][3];
  int          st  [4];

  mux_tree_pipe_if #(.DATA_W(8), .N_IN(8)) if0 ();
  mux_tree_pipe_if #(.DATA_W(8), .N_IN(8)) if1 ();
  mux_tree_pipe_if #(.DATA_W(8), .N_IN(8)) if2 ();
  mux_tree_pipe_if #(.DATA_W(8), .N_IN(5)) if3 ();

  assign if0.CE = ce;  assign if0.I = i8;  assign if0.S = s8;  assign if0.VI = vi;
  assign if1.CE = ce;  assign if1.I = i8;  assign if1.S = s8;  assign if1.VI = vi;
  assign if2.CE = ce;  assign if2.I = i8;  assign if2.S = s8;  assign if2.VI = vi;
  assign if3.CE = ce;  assign if3.I = i5;  assign if3.S = s5;  assign if3.VI = vi;

  mux_tree_pipe #(.DATA_W(8), .N_IN(8), .REG_EVERY(1)) u0 (.CLK(clk), .RST(rst), .bus(if0));
  mux_tree_pipe #(.DATA_W(8), .N_IN(8), .REG_EVERY(2)) u1 (.CLK(clk), .RST(rst), .bus(if1));
  mux_tree_pipe #(.DATA_W(8), .N_IN(8), .REG_EVERY(3)) u2 (.CLK(clk), .RST(rst), .bus(if2));
  mux_tree_pipe #(.DATA_W(8), .N_IN(5), .REG_EVERY(1)) u3 (.CLK(clk), .RST(rst), .bus(if3));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input string tag, input int d, input logic [7:0] o,
                     input logic v, input logic e);
    chk({tag, "_O"},   o,     m_o[d][st[d]-1]);
    chk({tag, "_VO"},  8'(v), 8'(m_v[d][st[d]-1]));
    chk({tag, "_ERR"}, 8'(e), 8'(m_e[d][st[d]-1]));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    logic [7:0] nd [4];
    logic       ne [4];
    for (int d = 0; d < 3; d++) begin
      nd[d] = 8'h10 + 8'(s8);
      ne[d] = 1'b0;
    end
    ne[3] = (s5 >= 3'd5);
    nd[3] = ne[3] ? 8'h00 : 8'hA0 + 8'(s5);
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        for (int s = 0; s < 3; s++) begin
          m_o[d][s] = 8'h00; m_v[d][s] = 1'b0; m_e[d][s] = 1'b0;
        end
      end else if (ce) begin
        for (int s = 2; s > 0; s--) begin
          m_o[d][s] = m_o[d][s-1]; m_v[d][s] = m_v[d][s-1]; m_e[d][s] = m_e[d][s-1];
        end
        m_o[d][0] = nd[d]; m_v[d][0] = vi; m_e[d][0] = ne[d];
      end
    end
    cmp("r1", 0, if0.O, if0.VO, if0.ERR);
    cmp("r2", 1, if1.O, if1.VO, if1.ERR);
    cmp("r3", 2, if2.O, if2.VO, if2.ERR);
    cmp("n5", 3, if3.O, if3.VO, if3.ERR);
  endtask

  initial begin
    st[0] = 3; st[1] = 2; st[2] = 1; st[3] = 3;
    for (int k = 0; k < 8; k++) i8[k*8 +: 8] = 8'(16 + k);
    for (int k = 0; k < 5; k++) i5[k*8 +: 8] = 8'(160 + k);
    tab5 = '{3'd4, 3'd5, 3'd7, 3'd3, 3'd2, 3'd0, 3'd1, 3'd6};
    rst = 1'b1; ce = 1'b1; vi = 1'b1; s8 = 3'd0; s5 = 3'd0;

    // reset, including valid beats offered while RST is high
    tick();
    tick();
    rst = 1'b0; vi = 1'b0;
    chk("reset_O", if0.O, 8'h00);
    chk("reset_VO", 8'(if0.VO), 8'h00);
    chk("reset_ERR", 8'(if3.ERR), 8'h00);

    // sweep S = 0..7; N_IN=5 instance sees in-range and out-of-range selects
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin s8 = 3'(k); s5 = tab5[k]; vi = 1'b1; end
      else       begin s8 = 3'd0;  s5 = 3'd0;    vi = 1'b0; end
      tick();
      if (k == 0) chk("lat1_first", if2.O, 8'h10);
      if (k == 1) chk("lat2_first", if1.O, 8'h10);
      if (k == 1) chk("lat3_early_VO", 8'(if0.VO), 8'h00);
      if (k == 2) chk("lat3_first", if0.O, 8'h10);
      if (k == 2) chk("oor_s4_O", if3.O, 8'hA4);
      if (k == 3) chk("oor_s5_O", if3.O, 8'h00);
      if (k == 3) chk("oor_s5_ERR", 8'(if3.ERR), 8'h01);
      if (k == 4) chk("oor_s7_ERR", 8'(if3.ERR), 8'h01);
      if (k == 4) chk("oor_s7_VO", 8'(if3.VO), 8'h01);
      if (k == 9) chk("sweep_last", if0.O, 8'h17);
    end

    // CE stall of 4 cycles after beat 2; inputs change but must not be taken
    for (int k = 0; k < 8; k++) begin
      s8 = 3'(k); s5 = 3'(k); vi = 1'b1;
      tick();
      if (k == 2) begin
        ce = 1'b0; s8 = 3'd5; s5 = 3'd6;
        for (int c = 0; c < 4; c++) begin
          tick();
          chk("stall_hold_O", if0.O, 8'h10);
          chk("stall_hold_VO", 8'(if0.VO), 8'h01);
        end
        ce = 1'b1;
      end
    end
    vi = 1'b0; s8 = 3'd0; s5 = 3'd0;
    for (int c = 0; c < 4; c++) tick();

    // reset with beats in flight, then a fresh beat S = 6
    vi = 1'b1; s8 = 3'd1; tick();
    s8 = 3'd2; tick();
    s8 = 3'd3; rst = 1'b1; tick();
    rst = 1'b0;
    chk("midrst_O", if0.O, 8'h00);
    chk("midrst_VO", 8'(if0.VO), 8'h00);
    s8 = 3'd6; vi = 1'b1; tick();
    chk("midrst_gap1_VO", 8'(if0.VO), 8'h00);
    s8 = 3'd0; vi = 1'b0; tick();
    chk("midrst_gap2_VO", 8'(if0.VO), 8'h00);
    tick();
    chk("midrst_new_O", if0.O, 8'h16);
    chk("midrst_new_VO", 8'(if0.VO), 8'h01);

    // bubbles: VI alternates while S increments
    for (int k = 0; k < 12; k++) begin
      s8 = 3'(k); s5 = 3'(k); vi = ((k % 2) == 0);
      tick();
    end
    vi = 1'b0;
    for (int c = 0; c < 4; c++) tick();

    // RST wins over CE = 0
    ce = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; ce = 1'b1;
    chk("rst_over_ce_O", if0.O, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
